instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 38 +++
 rtl/instr_encoder.sv | 125 ++++++++++++
 tb/tb_instr_encoder.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// ============================================================================
// Module      : instr_encoder_if
// Description : Request, instruction-memory write and status signals of the
//               RV32I instruction encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_encoder_if;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [12:0] imm;
    logic        wr_en;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [15:0] count;
    logic        err;

    modport master (
        output clear, req_valid, req_kind, rd, rs1, rs2, funct3, funct7b5, imm, wr_ready,
        input  req_ready, wr_en, wr_addr, wr_data, count, err
    );

    modport slave (
        input  clear, req_valid, req_kind, rd, rs1, rs2, funct3, funct7b5, imm, wr_ready,
        output req_ready, wr_en, wr_addr, wr_data, count, err
    );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Encodes load/store/R-type/branch requests into RV32I words and
//               streams them to instruction memory at consecutive addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          AW        = 12
) (
    input  wire logic       clk,
    input  wire logic       rst,
    instr_encoder_if.slave  bus
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [15:0] r_count;
    logic        r_err;
    logic [31:0] w_addr_adv;
    logic [31:0] w_word;
    logic        w_wr_en;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_handshake;
    logic        w_misaligned;
    logic        w_emit;

    // Only the low AW address bits advance; the rest stay pinned to the base.
    generate
        if (AW >= 32) begin : g_addr_full
            assign w_addr_adv = r_addr + 32'd4;
        end else begin : g_addr_wrap
            logic [AW-1:0] w_low_adv;
            assign w_low_adv  = r_addr[AW-1:0] + AW'(4);
            assign w_addr_adv = {r_addr[31:AW], w_low_adv};
        end
    endgenerate

    always_comb begin
        w_word = 32'd0;
        case (bus.req_kind)
            2'b00: w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, c_OP_LOAD};
            2'b01: w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], c_OP_STORE};
            2'b10: w_word = {1'b0, bus.funct7b5, 5'b00000, bus.rs2, bus.rs1, bus.funct3, bus.rd, c_OP_RTYPE};
            default: w_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                               bus.imm[4:1], bus.imm[11], c_OP_BRANCH};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_en      = (r_state == S_HOLD);
        // rst is folded in so the handshake is closed while reset is held.
        w_req_ready  = !rst && !bus.clear && (!w_wr_en || bus.wr_ready);
        w_accept     = bus.req_valid && w_req_ready;
        w_handshake  = w_wr_en && bus.wr_ready && !bus.clear;
        w_misaligned = (bus.req_kind == 2'b11) && bus.imm[0];
        w_emit       = w_accept && !w_misaligned;
        if (bus.clear) begin
            w_state_nxt = S_IDLE;
        end else if (w_emit) begin
            w_state_nxt = S_HOLD;
        end else if (w_handshake) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= BASE_ADDR;
            r_data  <= 32'd0;
            r_count <= 16'd0;
            r_err   <= 1'b0;
        end else if (bus.clear) begin
            r_addr  <= BASE_ADDR;
            r_count <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            // A word accepted alongside a handshake lands at the advanced address.
            if (w_handshake) begin
                r_addr  <= w_addr_adv;
                r_count <= r_count + 16'd1;
            end
            if (w_emit) begin
                r_data <= w_word;
            end
            if (w_accept && w_misaligned) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.wr_en     = w_wr_en;
    assign bus.wr_addr   = r_addr;
    assign bus.wr_data   = r_data;
    assign bus.count     = r_count;
    assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Scoreboard bench for instr_encoder with a narrow address field
//               and a non-zero base so wrapping and fixed upper bits show up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam logic [31:0] c_BASE = 32'h8000_0020;
    localparam int          c_AW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if bus ();

    instr_encoder #(.BASE_ADDR(c_BASE), .AW(c_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] sb_addr  = c_BASE;
    logic [15:0] sb_count = 16'd0;
    logic [31:0] sb_exp;
    logic [31:0] pend_data;
    logic        pend_mis;

    function automatic logic [31:0] enc(input logic [1:0] k, input logic [4:0] rd_i,
                                        input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                                        input logic [2:0] f3, input logic f7,
                                        input logic [12:0] im);
        case (k)
            2'b00:   return {im[11:0], rs1_i, f3, rd_i, 7'b0000011};
            2'b01:   return {im[11:5], rs2_i, rs1_i, f3, im[4:0], 7'b0100011};
            2'b10:   return {1'b0, f7, 5'd0, rs2_i, rs1_i, f3, rd_i, 7'b0110011};
            default: return {im[12], im[10:5], rs2_i, rs1_i, f3, im[4:1], im[11], 7'b1100011};
        endcase
    endfunction

    // A handshake seen mid-cycle completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && bus.wr_en && bus.wr_ready && !bus.clear) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word actual data=%h addr=%h required no word", bus.wr_data, bus.wr_addr);
            end else begin
                sb_exp = sb_q.pop_front();
                if (bus.wr_data !== sb_exp) begin
                    failures++;
                    $display("FAIL wr_data actual=%h required=%h", bus.wr_data, sb_exp);
                end
                checks++;
                if (bus.wr_addr !== sb_addr) begin
                    failures++;
                    $display("FAIL wr_addr actual=%h required=%h", bus.wr_addr, sb_addr);
                end
                checks++;
                if (bus.count !== sb_count) begin
                    failures++;
                    $display("FAIL count_at_handshake actual=%0d required=%0d", bus.count, sb_count);
                end
            end
            sb_addr  = {sb_addr[31:c_AW], sb_addr[c_AW-1:0] + 4'd4};
            sb_count = sb_count + 16'd1;
        end
    end

    task automatic drive_req(input logic [1:0] k, input logic [4:0] rd_i, input logic [4:0] rs1_i,
                             input logic [4:0] rs2_i, input logic [2:0] f3, input logic f7,
                             input logic [12:0] im, input logic [31:0] exp_w);
        bus.req_valid = 1'b1;
        bus.req_kind  = k;
        bus.rd        = rd_i;
        bus.rs1       = rs1_i;
        bus.rs2       = rs2_i;
        bus.funct3    = f3;
        bus.funct7b5  = f7;
        bus.imm       = im;
        pend_data     = exp_w;
        pend_mis      = (k == 2'b11) && im[0];
    endtask

    task automatic wait_accept();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                if (!pend_mis) sb_q.push_back(pend_data);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no accept required=accept within 50 cycles");
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [4:0] rd_i, input logic [4:0] rs1_i,
                        input logic [4:0] rs2_i, input logic [2:0] f3, input logic f7,
                        input logic [12:0] im, input logic [31:0] exp_w);
        drive_req(k, rd_i, rs1_i, rs2_i, f3, f7, im, exp_w);
        wait_accept();
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        sb_q.delete();
        sb_addr  = c_BASE;
        sb_count = 16'd0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_req_ready actual=%b required=0", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.wr_en, bus.wr_data, bus.wr_addr, bus.count, bus.err, bus.req_ready} !==
            {1'b0, 32'd0, c_BASE, 16'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state actual wr_en=%b data=%h addr=%h count=%0d err=%b rdy=%b required 0/0/%h/0/0/0",
                     bus.wr_en, bus.wr_data, bus.wr_addr, bus.count, bus.err, bus.req_ready, c_BASE);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset actual=%b required=1", bus.req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load();
        send(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, 1'b0, 13'd8, 32'h00812283);
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_data !== 32'h00812283) begin
            failures++;
            $display("FAIL load_latency actual wr_en=%b data=%h required 1/00812283", bus.wr_en, bus.wr_data);
        end
        idle(2);
        checks++;
        if (bus.count !== 16'd1 || bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL load_count actual count=%0d wr_en=%b required 1/0", bus.count, bus.wr_en);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        send(2'b01, 5'd0, 5'd2, 5'd6, 3'b010, 1'b0, 13'd12, 32'h00612623);
        send(2'b10, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 13'd0, 32'h002081B3);
        send(2'b10, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 13'd0, 32'h402081B3);
        idle(2);
        checks++;
        if (bus.count !== 16'd3 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count actual count=%0d pending=%0d required 3/0", bus.count, sb_q.size());
        end
    endtask

    task automatic test_branch();
        send(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 13'h1FF8, 32'hFE208CE3);
        idle(2);
        checks++;
        if (bus.count !== 16'd4) begin
            failures++;
            $display("FAIL branch_count actual=%0d required=4", bus.count);
        end
        send(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 13'h0005, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b0 || bus.err !== 1'b1 || bus.count !== 16'd4) begin
            failures++;
            $display("FAIL misaligned actual wr_en=%b err=%b count=%0d required 0/1/4", bus.wr_en, bus.err, bus.count);
        end
        idle(2);
        checks++;
        if (bus.count !== 16'd4 || bus.wr_addr !== {c_BASE[31:4], 4'h0}) begin
            failures++;
            $display("FAIL misaligned_hold actual count=%0d addr=%h required 4/%h", bus.count, bus.wr_addr, c_BASE);
        end
    endtask

    task automatic test_backpressure();
        bus.wr_ready = 1'b0;
        send(2'b00, 5'd7, 5'd9, 5'd0, 3'b011, 1'b0, 13'h0FFC, enc(2'b00, 5'd7, 5'd9, 5'd0, 3'b011, 1'b0, 13'h0FFC));
        drive_req(2'b01, 5'd0, 5'd4, 5'd8, 3'b001, 1'b0, 13'h1F40, enc(2'b01, 5'd0, 5'd4, 5'd8, 3'b001, 1'b0, 13'h1F40));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.wr_en !== 1'b1 || bus.req_ready !== 1'b0 || bus.wr_data !== sb_q[0] || bus.wr_addr !== sb_addr) begin
                failures++;
                $display("FAIL backpressure_hold cycle=%0d actual wr_en=%b rdy=%b data=%h addr=%h required 1/0/%h/%h",
                         i, bus.wr_en, bus.req_ready, bus.wr_data, bus.wr_addr, sb_q[0], sb_addr);
            end
            @(posedge clk);
            #1;
        end
        bus.wr_ready = 1'b1;
        wait_accept();
        send(2'b10, 5'd31, 5'd30, 5'd29, 3'b111, 1'b1, 13'd0, enc(2'b10, 5'd31, 5'd30, 5'd29, 3'b111, 1'b1, 13'd0));
        send(2'b11, 5'd0, 5'd17, 5'd18, 3'b101, 1'b0, 13'h0FFE, enc(2'b11, 5'd0, 5'd17, 5'd18, 3'b101, 1'b0, 13'h0FFE));
        idle(3);
        checks++;
        if (bus.count !== 16'd8 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL backpressure_count actual count=%0d pending=%0d required 8/0", bus.count, sb_q.size());
        end
    endtask

    task automatic test_wrap();
        do_clear();
        for (int i = 0; i < 4; i++) begin
            send(2'b10, 5'(i + 1), 5'(i + 2), 5'(i + 3), 3'(i), 1'(i), 13'd0,
                 enc(2'b10, 5'(i + 1), 5'(i + 2), 5'(i + 3), 3'(i), 1'(i), 13'd0));
        end
        idle(2);
        checks++;
        if (bus.wr_addr !== c_BASE || bus.count !== 16'd4) begin
            failures++;
            $display("FAIL wrap actual addr=%h count=%0d required %h/4", bus.wr_addr, bus.count, c_BASE);
        end
    endtask

    task automatic test_clear_hold();
        send(2'b11, 5'd0, 5'd1, 5'd1, 3'b001, 1'b0, 13'h0003, 32'd0);
        bus.wr_ready = 1'b0;
        send(2'b00, 5'd1, 5'd2, 5'd0, 3'b000, 1'b0, 13'd4, enc(2'b00, 5'd1, 5'd2, 5'd0, 3'b000, 1'b0, 13'd4));
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.err !== 1'b1) begin
            failures++;
            $display("FAIL pre_clear actual wr_en=%b err=%b required 1/1", bus.wr_en, bus.err);
        end
        @(posedge clk);
        #1;
        bus.wr_ready = 1'b1;
        do_clear();
        @(negedge clk);
        checks++;
        if ({bus.wr_en, bus.count, bus.wr_addr, bus.err} !== {1'b0, 16'd0, c_BASE, 1'b0}) begin
            failures++;
            $display("FAIL clear_drop actual wr_en=%b count=%0d addr=%h err=%b required 0/0/%h/0",
                     bus.wr_en, bus.count, bus.wr_addr, bus.err, c_BASE);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        send(2'b00, 5'd3, 5'd4, 5'd0, 3'b010, 1'b0, 13'd16, enc(2'b00, 5'd3, 5'd4, 5'd0, 3'b010, 1'b0, 13'd16));
        send(2'b01, 5'd0, 5'd4, 5'd3, 3'b010, 1'b0, 13'd20, enc(2'b01, 5'd0, 5'd4, 5'd3, 3'b010, 1'b0, 13'd20));
        bus.wr_ready  = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.count !== 16'd1) begin
            failures++;
            $display("FAIL pre_async actual wr_en=%b count=%0d required 1/1", bus.wr_en, bus.count);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.wr_en, bus.count, bus.req_ready, bus.wr_addr} !== {1'b0, 16'd0, 1'b0, c_BASE}) begin
            failures++;
            $display("FAIL async_reset actual wr_en=%b count=%0d rdy=%b addr=%h required 0/0/0/%h",
                     bus.wr_en, bus.count, bus.req_ready, bus.wr_addr, c_BASE);
        end
        sb_q.delete();
        sb_addr  = c_BASE;
        sb_count = 16'd0;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.wr_ready = 1'b1;
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_kind  = 2'b00;
        bus.rd        = 5'd0;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;
        bus.funct3    = 3'd0;
        bus.funct7b5  = 1'b0;
        bus.imm       = 13'd0;
        bus.wr_ready  = 1'b1;
        pend_data     = 32'd0;
        pend_mis      = 1'b0;
        test_reset();
        test_load();
        test_back_to_back();
        test_branch();
        test_backpressure();
        test_wrap();
        test_clear_hold();
        test_async_reset();
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
